// File: rtl/shru_lsu_arbiter_pkg.sv
// shru_pkg: shared types and helpers for the ShRU/LSU store arbiter.
//   DATA_WIDTH          operand width (XLEN)
//   SHRU_PAGE_OFFSET_W  width of a page offset
//   arb_state_e         arbiter states IDLE / SHRU / FAIR
//   fu_data_t           FU request (operand_a, imm, fu, operation, trans_id)
//   page_offset_of()    page offset addressed by a request: (operand_a + imm)[11:0]
package shru_pkg;

    localparam int unsigned DATA_WIDTH         = 32;
    localparam int unsigned SHRU_PAGE_OFFSET_W = 12;

    typedef enum logic [1:0] {IDLE, SHRU, FAIR} arb_state_e;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] operand_a;
        logic [DATA_WIDTH-1:0] imm;
        logic [3:0]            fu;
        logic [6:0]            operation;
        logic [2:0]            trans_id;
    } fu_data_t;

    function automatic logic [SHRU_PAGE_OFFSET_W-1:0] page_offset_of(input fu_data_t d);
        logic [DATA_WIDTH-1:0] sum;
        sum = d.operand_a + d.imm;
        return sum[SHRU_PAGE_OFFSET_W-1:0];
    endfunction

endpackage

// File: rtl/shru_lsu_arbiter_store_fifo.sv
// shru_store_fifo: strict-order buffer for ShRU stores with per-entry page-offset compare.
//   clk_i, rst_ni   clock, asynchronous active-low reset (discards contents)
//   push_i, data_i  write an entry (caller guarantees !full_o)
//   pop_i, head_o   remove the oldest entry (caller guarantees !empty_o)
//   full_o, empty_o, count_o  occupancy from registered state
//   page_offset_i   offset to compare against every valid entry
//   match_o         per-entry hit vector
module shru_store_fifo
    import shru_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          push_i,
    input  fu_data_t                      data_i,
    input  logic                          pop_i,
    output fu_data_t                      head_o,
    output logic                          full_o,
    output logic                          empty_o,
    output logic [$clog2(DEPTH):0]        count_o,
    input  logic [SHRU_PAGE_OFFSET_W-1:0] page_offset_i,
    output logic [DEPTH-1:0]              match_o
);

    localparam int unsigned PTR_W = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    fu_data_t         mem_q [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;

    // Explicit wrap keeps DEPTH == 1 correct, where the pointer has a spare bit.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= '0;
        end else begin
            if (pop_i) begin
                rd_ptr_q          <= ptr_inc(rd_ptr_q);
                valid_q[rd_ptr_q] <= 1'b0;
            end
            if (push_i) begin
                wr_ptr_q          <= ptr_inc(wr_ptr_q);
                valid_q[wr_ptr_q] <= 1'b1;
            end
            count_q <= count_q + CNT_W'(push_i) - CNT_W'(pop_i);
        end
    end

    // Payload storage needs no reset: valid_q qualifies every use.
    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_ptr_q] <= data_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign full_o  = count_q == CNT_W'(DEPTH);
    assign empty_o = count_q == '0;
    assign count_o = count_q;

    always_comb begin
        for (int i = 0; i < DEPTH; i++)
            match_o[i] = valid_q[i] && (page_offset_of(mem_q[i]) == page_offset_i);
    end

endmodule

// File: rtl/shru_lsu_arbiter.sv
// shru_lsu_arbiter: buffers ShRU store requests and arbitrates them with issue-stage
// requests onto the single LSU port, with a burst limit so issue is not starved.
//   clk_i, rst_ni                           clock, asynchronous active-low reset
//   shru_valid_i, shru_fu_data_i            ShRU store request
//   shru_store_valid_o                      ShRU request accepted this cycle
//   issue_valid_i, issue_fu_data_i          issue-stage LSU request
//   issue_ready_o                           issue request accepted this cycle
//   lsu_ready_i, lsu_valid_o, lsu_fu_data_o LSU port
//   page_offset_i, page_offset_matches_o    load offset vs. pending ShRU stores
//   flush_i                                 kills the issue side for this cycle
// Build option SHRU_ARB_BYPASS_EN: with an empty buffer, outside FAIR and with the LSU
// ready, a ShRU request goes straight to the LSU in the same cycle.
module shru_lsu_arbiter
    import shru_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH     = 2,
    parameter int unsigned MAX_SHRU_BURST = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          shru_valid_i,
    input  fu_data_t                      shru_fu_data_i,
    output logic                          shru_store_valid_o,
    input  logic                          issue_valid_i,
    input  fu_data_t                      issue_fu_data_i,
    output logic                          issue_ready_o,
    input  logic                          lsu_ready_i,
    output logic                          lsu_valid_o,
    output fu_data_t                      lsu_fu_data_o,
    input  logic [SHRU_PAGE_OFFSET_W-1:0] page_offset_i,
    output logic                          page_offset_matches_o,
    input  logic                          flush_i
);

    localparam int unsigned CNT_W = $clog2(MAX_SHRU_BURST) + 1;
    localparam int unsigned OCC_W = $clog2(FIFO_DEPTH) + 1;

    arb_state_e            state_q, state_d;
    logic [CNT_W-1:0]      burst_q, burst_d;
    fu_data_t              head;
    logic                  fifo_full, fifo_empty, push, pop, bypass;
    logic                  grant_shru, grant_issue, shru_xfer, issue_xfer;
    logic                  nonempty_next, burst_last, fair_hold;
    logic [OCC_W-1:0]      occ;
    logic [FIFO_DEPTH-1:0] match_vec;

`ifdef SHRU_ARB_BYPASS_EN
    assign bypass = fifo_empty && shru_valid_i && state_q != FAIR && lsu_ready_i;
`else
    assign bypass = 1'b0;
`endif

    shru_store_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .push_i       (push),
        .data_i       (shru_fu_data_i),
        .pop_i        (pop),
        .head_o       (head),
        .full_o       (fifo_full),
        .empty_o      (fifo_empty),
        .count_o      (occ),
        .page_offset_i(page_offset_i),
        .match_o      (match_vec)
    );

    always_comb begin
        grant_shru         = state_q != FAIR && (!fifo_empty || bypass);
        grant_issue        = !grant_shru && !flush_i;
        // Full is judged on registered occupancy only: no accept-on-pop when full.
        shru_store_valid_o = shru_valid_i && !fifo_full;
        push               = shru_store_valid_o && !bypass;
        lsu_valid_o        = grant_shru || (grant_issue && issue_valid_i);
        lsu_fu_data_o      = !lsu_valid_o ? '0 : bypass ? shru_fu_data_i : grant_shru ? head : issue_fu_data_i;
        shru_xfer          = grant_shru && lsu_ready_i;
        pop                = shru_xfer && !bypass;
        issue_xfer         = grant_issue && issue_valid_i && lsu_ready_i;
        issue_ready_o      = issue_xfer;
        nonempty_next      = (occ + OCC_W'(push) - OCC_W'(pop)) != '0;
        burst_last         = burst_q == CNT_W'(MAX_SHRU_BURST - 1);
        // Counting only matters while ShRU is actually holding off a waiting issue request.
        burst_d            = (!issue_valid_i || !grant_shru) ? '0 :
                             shru_xfer ? (burst_last ? '0 : burst_q + CNT_W'(1)) : burst_q;
        // FAIR is released by the issue transfer, a flush, or issue no longer waiting.
        fair_hold          = state_q == FAIR && !issue_xfer && !flush_i && issue_valid_i;
        state_d            = fair_hold ? FAIR :
                             (shru_xfer && issue_valid_i && burst_last) ? FAIR :
                             nonempty_next ? SHRU : IDLE;
        page_offset_matches_o = |match_vec || (bypass && page_offset_of(shru_fu_data_i) == page_offset_i);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            burst_q <= '0;
        end else begin
            state_q <= state_d;
            burst_q <= burst_d;
        end
    end

endmodule
